// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// the load writeback code and the memory-wait FSM states.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  localparam logic [1:0] WSEL_LOAD = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Per-operand forwarding: finds the youngest stage writing the source register.
// A load still in EX cannot forward; it reports a load-use hazard instead.
module fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       re_i,
  input  logic [4:0] ex_wr_i,
  input  logic       ex_we_i,
  input  logic       ex_load_i,
  input  logic [4:0] mem_wr_i,
  input  logic       mem_we_i,
  input  logic [4:0] wb_wr_i,
  input  logic       wb_we_i,
  output logic [1:0] sel_o,
  output logic       load_use_o
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // x0 is hardwired to zero, so a write to it never carries a value
  assign ex_hit  = re_i && ex_we_i  && (ex_wr_i  != 5'd0) && (ex_wr_i  == src_i);
  assign mem_hit = re_i && mem_we_i && (mem_wr_i != 5'd0) && (mem_wr_i == src_i);
  assign wb_hit  = re_i && wb_we_i  && (wb_wr_i  != 5'd0) && (wb_wr_i  == src_i);

  always_comb begin
    sel_o      = FWD_RF;
    load_use_o = ex_hit && ex_load_i;
    if (ex_hit && !ex_load_i) begin
      sel_o = FWD_EX;
    end else if (mem_hit) begin
      sel_o = FWD_MEM;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use stall, jump flush
// and a registered memory-wait/timeout FSM. Define HAZARD_PERF_EN for perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_re1_i,
  input  logic       id_re2_i,
  input  logic [4:0] ex_wR_i,
  input  logic       ex_rf_we_i,
  input  logic [1:0] ex_rf_wsel_i,
  input  logic [4:0] mem_wR_i,
  input  logic       mem_rf_we_i,
  input  logic [4:0] wb_wR_i,
  input  logic       wb_rf_we_i,
  input  logic       ex_jump_i,
  input  logic       mem_req_i,
  input  logic       mem_ack_i,
  output logic       stall_pc_o,
  output logic       stall_if_id_o,
  output logic       flush_if_id_o,
  output logic       flush_id_ex_o,
  output logic       pipeline_stop_o,
  output logic [1:0] fwd_rs1_o,
  output logic [1:0] fwd_rs2_o,
  output logic       err_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ex_load;
  logic lu_rs1, lu_rs2;
  logic frozen;
  logic hazard_act;
  logic jump_act;
  logic lu_act;

  assign ex_load = (ex_rf_wsel_i == WSEL_LOAD);

  fwd_unit u_fwd_rs1 (
    .src_i      (id_rs1_i),
    .re_i       (id_re1_i),
    .ex_wr_i    (ex_wR_i),
    .ex_we_i    (ex_rf_we_i),
    .ex_load_i  (ex_load),
    .mem_wr_i   (mem_wR_i),
    .mem_we_i   (mem_rf_we_i),
    .wb_wr_i    (wb_wR_i),
    .wb_we_i    (wb_rf_we_i),
    .sel_o      (fwd_rs1_o),
    .load_use_o (lu_rs1)
  );

  fwd_unit u_fwd_rs2 (
    .src_i      (id_rs2_i),
    .re_i       (id_re2_i),
    .ex_wr_i    (ex_wR_i),
    .ex_we_i    (ex_rf_we_i),
    .ex_load_i  (ex_load),
    .mem_wr_i   (mem_wR_i),
    .mem_we_i   (mem_rf_we_i),
    .wb_wr_i    (wb_wR_i),
    .wb_we_i    (wb_rf_we_i),
    .sel_o      (fwd_rs2_o),
    .load_use_o (lu_rs2)
  );

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        // a dropped request without ack is an abort, same exit as an ack
        if (mem_ack_i || !mem_req_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
          state_d = ST_ERR;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The ack cycle is already unfrozen, so a jump held in EX is flushed there.
  always_comb begin
    frozen     = rst_n && (((state_q == ST_WAIT) && !mem_ack_i) || (state_q == ST_ERR));
    hazard_act = rst_n && !frozen;
    jump_act   = hazard_act && ex_jump_i;
    lu_act     = hazard_act && (lu_rs1 || lu_rs2);

    stall_pc_o      = frozen || (lu_act && !jump_act);
    stall_if_id_o   = frozen || (lu_act && !jump_act);
    flush_if_id_o   = jump_act;
    flush_id_ex_o   = jump_act || lu_act;
    pipeline_stop_o = frozen;
    err_o           = (state_q == ST_ERR);
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_pc_o    ? stall_cnt_q + 32'd1 : stall_cnt_q;
    flush_cnt_d = flush_id_ex_o ? flush_cnt_q + 32'd1 : flush_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a behavioural model
// of the forwarding/stall rules and the memory-wait sequence.
module tb_hazard_ctrl;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1_i, id_rs2_i;
  logic       id_re1_i, id_re2_i;
  logic [4:0] ex_wR_i;
  logic       ex_rf_we_i;
  logic [1:0] ex_rf_wsel_i;
  logic [4:0] mem_wR_i;
  logic       mem_rf_we_i;
  logic [4:0] wb_wR_i;
  logic       wb_rf_we_i;
  logic       ex_jump_i, mem_req_i, mem_ack_i;
  logic       stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o;
  logic       pipeline_stop_o, err_o;
  logic [1:0] fwd_rs1_o, fwd_rs2_o;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt_o, perf_flush_cnt_o;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1_i        (id_rs1_i),
    .id_rs2_i        (id_rs2_i),
    .id_re1_i        (id_re1_i),
    .id_re2_i        (id_re2_i),
    .ex_wR_i         (ex_wR_i),
    .ex_rf_we_i      (ex_rf_we_i),
    .ex_rf_wsel_i    (ex_rf_wsel_i),
    .mem_wR_i        (mem_wR_i),
    .mem_rf_we_i     (mem_rf_we_i),
    .wb_wR_i         (wb_wR_i),
    .wb_rf_we_i      (wb_rf_we_i),
    .ex_jump_i       (ex_jump_i),
    .mem_req_i       (mem_req_i),
    .mem_ack_i       (mem_ack_i),
    .stall_pc_o      (stall_pc_o),
    .stall_if_id_o   (stall_if_id_o),
    .flush_if_id_o   (flush_if_id_o),
    .flush_id_ex_o   (flush_id_ex_o),
    .pipeline_stop_o (pipeline_stop_o),
    .fwd_rs1_o       (fwd_rs1_o),
    .fwd_rs2_o       (fwd_rs2_o),
    .err_o           (err_o)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt_o(perf_stall_cnt_o),
    .perf_flush_cnt_o(perf_flush_cnt_o)
`endif
  );

  // Model: mode 0 = running, 1 = waiting on memory, 2 = timed out.
  int m_mode, m_cnt;
  int m_stalls, m_flushes;
  bit e_stall, e_flush;
  int n_vec, n_err;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit writes(input bit we, input int wr, input int src);
    return we && (wr != 0) && (wr == src);
  endfunction

  function automatic int ref_fwd(input int src, input bit re);
    if (!re) return 0;
    if (writes(ex_rf_we_i, ex_wR_i, src) && ex_rf_wsel_i != 2'd3) return 1;
    if (writes(mem_rf_we_i, mem_wR_i, src)) return 2;
    if (writes(wb_rf_we_i, wb_wR_i, src)) return 3;
    return 0;
  endfunction

  function automatic bit ref_lu(input int src, input bit re);
    return re && writes(ex_rf_we_i, ex_wR_i, src) && ex_rf_wsel_i == 2'd3;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic evaluate();
    bit frozen, jmp, lu;
    frozen = rst_n && ((m_mode == 1 && !mem_ack_i) || m_mode == 2);
    jmp    = rst_n && !frozen && ex_jump_i;
    lu     = rst_n && !frozen && (ref_lu(id_rs1_i, id_re1_i) || ref_lu(id_rs2_i, id_re2_i));
    e_stall = frozen || (lu && !jmp);
    e_flush = jmp || lu;
    check("stall_pc",      stall_pc_o,      e_stall);
    check("stall_if_id",   stall_if_id_o,   e_stall);
    check("flush_if_id",   flush_if_id_o,   jmp);
    check("flush_id_ex",   flush_id_ex_o,   e_flush);
    check("pipeline_stop", pipeline_stop_o, frozen);
    check("err",           err_o,           rst_n && m_mode == 2);
    check("fwd_rs1",       fwd_rs1_o,       ref_fwd(id_rs1_i, id_re1_i));
    check("fwd_rs2",       fwd_rs2_o,       ref_fwd(id_rs2_i, id_re2_i));
`ifdef HAZARD_PERF_EN
    check("perf_stall",    perf_stall_cnt_o, m_stalls);
    check("perf_flush",    perf_flush_cnt_o, m_flushes);
`endif
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (e_stall) m_stalls++;
    if (e_flush) m_flushes++;
    case (m_mode)
      0: if (mem_req_i && !mem_ack_i) begin m_mode = 1; m_cnt = 1; end
      1: begin
        if (mem_ack_i || !mem_req_i) begin m_mode = 0; m_cnt = 0; end
        else if (m_cnt == T) m_mode = 2;
        else m_cnt++;
      end
      default: ;
    endcase
  endtask

  // Inputs are set by the caller just after a falling edge.
  task automatic step();
    if (!rst_n) model_reset();
    #1;
    evaluate();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs1_i = 5'd1; id_rs2_i = 5'd2; id_re1_i = 1'b0; id_re2_i = 1'b0;
    ex_wR_i = 5'd0; ex_rf_we_i = 1'b0; ex_rf_wsel_i = 2'd0;
    mem_wR_i = 5'd0; mem_rf_we_i = 1'b0; wb_wR_i = 5'd0; wb_rf_we_i = 1'b0;
    ex_jump_i = 1'b0; mem_req_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic load_use_x7();
    idle();
    ex_wR_i = 5'd7; ex_rf_we_i = 1'b1; ex_rf_wsel_i = 2'd3;
    id_rs2_i = 5'd7; id_re2_i = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    model_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    // reset with hazards on the inputs: controls stay low, fwd follows inputs
    load_use_x7();
    ex_jump_i = 1'b1; mem_wR_i = 5'd2; mem_rf_we_i = 1'b1;
    id_rs1_i = 5'd2; id_re1_i = 1'b1;
    step();
    check("rst_flush_id_ex", flush_id_ex_o, 0);
    check("rst_fwd_rs1", fwd_rs1_o, 2);
    idle();
    rst_n = 1'b1;
    step();

    // randomized traffic; timeout avoided here and exercised below
    for (int i = 0; i < 400; i++) begin
      id_rs1_i = 5'($urandom_range(0, 3)); id_rs2_i = 5'($urandom_range(0, 3));
      id_re1_i = 1'($urandom); id_re2_i = 1'($urandom);
      ex_wR_i = 5'($urandom_range(0, 3)); ex_rf_we_i = 1'($urandom);
      ex_rf_wsel_i = 2'($urandom_range(0, 3));
      mem_wR_i = 5'($urandom_range(0, 3)); mem_rf_we_i = 1'($urandom);
      wb_wR_i = 5'($urandom_range(0, 3)); wb_rf_we_i = 1'($urandom);
      ex_jump_i = ($urandom_range(0, 4) == 0);
      if (m_mode == 1) begin
        mem_req_i = ($urandom_range(0, 9) != 0);
        mem_ack_i = (m_cnt >= T - 1) || ($urandom_range(0, 2) == 0);
      end else begin
        mem_req_i = ($urandom_range(0, 3) == 0);
        mem_ack_i = 1'($urandom);
      end
      step();
    end

    idle();
    do_reset();
    // forwarding priority and x0
    ex_wR_i = 5'd5; ex_rf_we_i = 1'b1; mem_wR_i = 5'd5; mem_rf_we_i = 1'b1;
    wb_wR_i = 5'd5; wb_rf_we_i = 1'b1; id_rs1_i = 5'd5; id_re1_i = 1'b1;
    step();
    check("plan_fwd_ex", fwd_rs1_o, 1);
    check("plan_no_stall", stall_pc_o, 0);
    ex_rf_we_i = 1'b0; step();
    check("plan_fwd_mem", fwd_rs1_o, 2);
    mem_rf_we_i = 1'b0; step();
    check("plan_fwd_wb", fwd_rs1_o, 3);
    idle(); ex_wR_i = 5'd0; ex_rf_we_i = 1'b1; id_rs1_i = 5'd0; id_re1_i = 1'b1;
    step();
    check("plan_fwd_x0", fwd_rs1_o, 0);

    // load-use then forward from MEM
    load_use_x7(); step();
    check("plan_lu_stall", stall_pc_o, 1);
    idle(); mem_wR_i = 5'd7; mem_rf_we_i = 1'b1; id_rs2_i = 5'd7; id_re2_i = 1'b1;
    step();
    check("plan_lu_fwd_mem", fwd_rs2_o, 2);
    check("plan_lu_released", stall_if_id_o, 0);

    // jump beats load-use
    load_use_x7(); ex_jump_i = 1'b1; step();
    check("plan_jump_no_stall", stall_pc_o, 0);
    check("plan_jump_flush", flush_if_id_o, 1);

    // wait with ack after 3 frozen cycles; jump held in EX
    idle(); mem_req_i = 1'b1; step();
    ex_jump_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("plan_wait_frozen", pipeline_stop_o, 1);
      check("plan_wait_no_flush", flush_if_id_o, 0);
    end
    mem_ack_i = 1'b1; step();
    check("plan_ack_unfrozen", pipeline_stop_o, 0);
    check("plan_ack_jump", flush_if_id_o, 1);
    idle(); step();

    // abort: request drops mid-wait
    mem_req_i = 1'b1; step(); step(); mem_req_i = 1'b0; step(); step();
    check("abort_run", stall_pc_o, 0);

    // timeout into sticky error, then reset clears it
    mem_req_i = 1'b1;
    for (int i = 0; i < 1 + T; i++) step();
    check("timeout_err", err_o, 1);
    mem_req_i = 1'b0; mem_ack_i = 1'b1; ex_jump_i = 1'b1; step(); step();
    check("err_sticky", err_o, 1);
    check("err_frozen", stall_pc_o, 1);
    rst_n = 1'b0; step();
    check("err_cleared", err_o, 0);
    idle(); rst_n = 1'b1; step();

    // reset asserted mid-wait
    mem_req_i = 1'b1; step(); step();
    ex_jump_i = 1'b1; rst_n = 1'b0; step();
    check("midwait_rst_stop", pipeline_stop_o, 0);
    idle(); rst_n = 1'b1; step();

    // perf: two load-use stalls plus a three-cycle wait
    do_reset();
    load_use_x7(); step(); idle(); step();
    load_use_x7(); step(); idle(); step();
    mem_req_i = 1'b1; step(); step(); step(); step();
    mem_ack_i = 1'b1; step(); idle(); step();
`ifdef HAZARD_PERF_EN
    check("plan_perf_stall", perf_stall_cnt_o, 5);
    check("plan_perf_flush", perf_flush_cnt_o, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline controller for the 5-stage core. It drives stall, flush and freeze for IF/ID, ID/EX, EX/MEM and MEM_WB, and generates the operand-forwarding selects for ID. A registered FSM sequences multi-cycle data-memory waits and a bus-timeout error.

Parameters:
MEM_TIMEOUT, 16, max cycles a data-memory request may wait for ack before ERR
CNT_W, 5, width of wait counter; must hold MEM_TIMEOUT

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous, active-low reset
id_rs1_i  in  5  ID source reg 1
id_rs2_i  in  5  ID source reg 2
id_re1_i  in  1  ID reads rs1
id_re2_i  in  1  ID reads rs2
ex_wR_i  in  5  EX dest reg
ex_rf_we_i  in  1  EX writes RF
ex_rf_wsel_i  in  2  EX writeback select; 2'd3 = load
mem_wR_i  in  5  MEM dest reg
mem_rf_we_i  in  1  MEM writes RF
wb_wR_i  in  5  WB dest reg
wb_rf_we_i  in  1  WB writes RF
ex_jump_i  in  1  EX branch taken / jump
mem_req_i  in  1  MEM stage issues data-memory access
mem_ack_i  in  1  data memory completes access
stall_pc_o  out  1  hold PC
stall_if_id_o  out  1  hold IF/ID
flush_if_id_o  out  1  bubble IF/ID
flush_id_ex_o  out  1  bubble ID/EX
pipeline_stop_o  out  1  hold EX/MEM and MEM_WB
fwd_rs1_o  out  2  0 RF, 1 EX, 2 MEM, 3 WB
fwd_rs2_o  out  2  same encoding for rs2
err_o  out  1  sticky memory-timeout error

Behaviour:
- Reset (rst_n=0, async): state=RUN, wait counter=0, err_o=0. Because of the comb dependence, stall/flush/stop are 0 while reset is asserted; fwd_* follow their inputs.
- Forwarding (comb):
  - A source matches a stage only if the stage's we=1, wR!=0, wR==src and the matching re=1.
  - Priority EX > MEM > WB; no match -> 0.
  - EX match with ex_rf_wsel_i==2'd3 never forwards from EX; it triggers load-use instead.
- Load-use (comb, state RUN): asserts stall_pc, stall_if_id and flush_id_ex for exactly one cycle. The load then sits in MEM and forwards as sel 2 on the next cycle.
- Jump (comb, state RUN): ex_jump_i asserts flush_if_id and flush_id_ex, with no PC stall. Jump beats load-use in the same cycle (no stall_pc).
- FSM, registered:
  - RUN: mem_req_i=1 and mem_ack_i=0 -> WAIT, counter=1. If req and ack arrive in the same cycle, stay in RUN with no freeze.
  - WAIT: freeze all, i.e. stall_pc, stall_if_id, pipeline_stop, and flush_id_ex=0. Because ID/EX must also hold, stall_id_ex is implied by pipeline_stop; ID/EX consumes pipeline_stop.
    - mem_ack_i=1 -> RUN. The freeze drops in that same cycle, so the ack cycle is not frozen.
    - counter==MEM_TIMEOUT with no ack -> ERR.
    - Otherwise counter+1 (saturating).
  - ERR: err_o=1 and all freezes held until reset. Jump and load-use are ignored.
- Freeze priority: in WAIT or ERR, jump and load-use outputs are suppressed. The jump stays visible in the frozen EX and is acted on the first RUN cycle.
- mem_req_i deasserting in WAIT without ack: treat as abort -> RUN next cycle, counter cleared.
- Reset mid-WAIT or in ERR: immediately RUN, err_o=0.

Optional Feature:
- HAZARD_PERF_EN defined: adds outputs perf_stall_cnt_o[31:0] and perf_flush_cnt_o[31:0].
  - perf_stall_cnt_o increments each cycle stall_pc_o=1; perf_flush_cnt_o increments each cycle flush_id_ex_o=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; function otherwise identical.

Decomposition:
- Shared package/header:
  - fwd select encodings FWD_RF/EX/MEM/WB
  - WSEL_LOAD=2'd3
  - FSM state encodings ST_RUN/ST_WAIT/ST_ERR
- Sub-module fwd_unit: pure comb per-operand match/priority; instantiated twice, rs1 and rs2.

Test Plan:
- EX add x5 (we=1, wsel=0), ID reads x5 on rs1 -> fwd_rs1_o=1, no stalls; x0 as dest -> fwd_rs1_o=0.
- EX load x7 (wsel=3), ID rs2=x7 -> one cycle stall_pc=stall_if_id=flush_id_ex=1; next cycle load in MEM -> fwd_rs2_o=2, stalls 0.
- ex_jump_i=1 together with load-use hazard -> flush_if_id=flush_id_ex=1, stall_pc=0.
- mem_req_i=1, ack after 3 cycles -> pipeline_stop/stall_pc high 3 cycles, low in the ack cycle; a simultaneous jump is flushed only after release.
- MEM_TIMEOUT=4, req held, no ack -> ERR after 4 WAIT cycles, err_o=1 sticky; rst_n pulse -> err_o=0, state RUN.
- With HAZARD_PERF_EN: 2 load-use stalls plus a 3-cycle wait -> perf_stall_cnt_o=5, perf_flush_cnt_o=2.
